// File: rtl/tcp_pkg.sv
// Shared TCP engine definitions.
// Holds the flow and timestamp widths, the per-flow retransmission timer
// entry, the default timeout, and the retransmission scanner state enum.
package tcp_pkg;

  localparam int          MAX_TCP_FLOWS     = 8;
  localparam int          FLOWID_W          = 3;
  localparam int          TIMESTAMP_W       = 64;
  localparam int unsigned RT_TIMEOUT_CYCLES = 32'd250000000;

  // One retransmission timer per flow. The timestamp holds the value of `now`
  // when the timer was last armed. It only has meaning while timer_armed = 1.
  typedef struct packed {
    logic [TIMESTAMP_W-1:0] timestamp;
    logic                   timer_armed;
  } tx_ack_timer_struct;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } rt_timer_state_e;

endpackage

// File: rtl/tcp_rt_timer_scan.sv
// Round-robin expiry scanner for the retransmission timer table.
// Each cycle it evaluates one entry in SCAN. It latches an expired flow and
// holds the notification in HOLD until the consumer accepts it.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   now                    free-running cycle count from the top
//   entry                  table entry currently addressed by scan_ptr
//   arm_val/arm_flowid     arm request seen this cycle (collision check)
//   scan_ptr               entry index the top must present on `entry`
//   clr_val/clr_flowid     clear-on-expire request to the table
//   timeout_val/_flowid    expired-flow notification
//   timeout_rdy            consumer accepts the notification
module tcp_rt_timer_scan
  import tcp_pkg::*;
#(
  parameter int          NUM_FLOWS      = MAX_TCP_FLOWS,
  parameter int unsigned TIMEOUT_CYCLES = RT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TIMESTAMP_W-1:0] now,
  input  tx_ack_timer_struct     entry,
  input  logic                   arm_val,
  input  logic [FLOWID_W-1:0]    arm_flowid,
  output logic [FLOWID_W-1:0]    scan_ptr,
  output logic                   clr_val,
  output logic [FLOWID_W-1:0]    clr_flowid,
  output logic                   timeout_val,
  output logic [FLOWID_W-1:0]    timeout_flowid,
  input  logic                   timeout_rdy
);

  localparam logic [TIMESTAMP_W-1:0] TIMEOUT_TS = TIMESTAMP_W'(TIMEOUT_CYCLES);
  localparam logic [FLOWID_W-1:0]    LAST_PTR   = FLOWID_W'(NUM_FLOWS - 1);

  rt_timer_state_e       state_q, state_d;
  logic [FLOWID_W-1:0]   scan_ptr_q, scan_ptr_d;
  logic                  timeout_val_q, timeout_val_d;
  logic [FLOWID_W-1:0]   timeout_flowid_q, timeout_flowid_d;

  logic [TIMESTAMP_W-1:0] age;
  logic                   expired;
  logic                   arm_hit;

  // The unsigned modular difference gives the correct age across a wrap of `now`.
  assign age     = now - entry.timestamp;
  assign expired = entry.timer_armed && (age >= TIMEOUT_TS);
  // An arm to the flow under evaluation restarts its timer. The expire is dropped.
  assign arm_hit = arm_val && (arm_flowid == scan_ptr_q);

  always_comb begin
    state_d          = state_q;
    scan_ptr_d       = scan_ptr_q;
    timeout_val_d    = timeout_val_q;
    timeout_flowid_d = timeout_flowid_q;
    clr_val          = 1'b0;

    unique case (state_q)
      SCAN: begin
        scan_ptr_d = (scan_ptr_q == LAST_PTR) ? '0 : scan_ptr_q + 1'b1;
        if (expired && !arm_hit) begin
          clr_val          = 1'b1;
          timeout_val_d    = 1'b1;
          timeout_flowid_d = scan_ptr_q;
          state_d          = HOLD;
        end
      end
      HOLD: begin
        if (timeout_rdy) begin
          timeout_val_d = 1'b0;
          state_d       = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= SCAN;
      scan_ptr_q       <= '0;
      timeout_val_q    <= 1'b0;
      timeout_flowid_q <= '0;
    end else begin
      state_q          <= state_d;
      scan_ptr_q       <= scan_ptr_d;
      timeout_val_q    <= timeout_val_d;
      timeout_flowid_q <= timeout_flowid_d;
    end
  end

  assign scan_ptr       = scan_ptr_q;
  assign clr_flowid     = scan_ptr_q;
  assign timeout_val    = timeout_val_q;
  assign timeout_flowid = timeout_flowid_q;

endmodule

// File: rtl/tcp_rt_timer.sv
// Per-flow TCP retransmission timer.
// The TX path arms a flow when it sends a segment. The RX ACK path disarms the
// flow when new data is acknowledged. A round-robin scanner reports expired
// flows to the retransmit engine over a valid/ready interface.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   arm_val/arm_flowid           arm or re-arm a flow (always accepted)
//   disarm_val/disarm_flowid     disarm a flow (always accepted)
//   timeout_val/timeout_flowid   expired-flow notification
//   timeout_rdy                  consumer accepts the notification
//   now                          free-running 64-bit cycle counter
module tcp_rt_timer
  import tcp_pkg::*;
#(
  parameter int          NUM_FLOWS      = MAX_TCP_FLOWS,
  parameter int unsigned TIMEOUT_CYCLES = RT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm_val,
  input  logic [FLOWID_W-1:0]    arm_flowid,
  input  logic                   disarm_val,
  input  logic [FLOWID_W-1:0]    disarm_flowid,
  output logic                   timeout_val,
  output logic [FLOWID_W-1:0]    timeout_flowid,
  input  logic                   timeout_rdy,
  output logic [TIMESTAMP_W-1:0] now
);

  logic [TIMESTAMP_W-1:0] now_q, now_d;
  tx_ack_timer_struct     tbl_q [NUM_FLOWS];
  tx_ack_timer_struct     tbl_d [NUM_FLOWS];

  logic [FLOWID_W-1:0]    scan_ptr;
  logic                   clr_val;
  logic [FLOWID_W-1:0]    clr_flowid;
  tx_ack_timer_struct     scan_entry;

  assign now_d      = now_q + 1'b1;
  assign scan_entry = tbl_q[scan_ptr];

  tcp_rt_timer_scan #(
    .NUM_FLOWS      (NUM_FLOWS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_scan (
    .clk            (clk),
    .rst_n          (rst_n),
    .now            (now_q),
    .entry          (scan_entry),
    .arm_val        (arm_val),
    .arm_flowid     (arm_flowid),
    .scan_ptr       (scan_ptr),
    .clr_val        (clr_val),
    .clr_flowid     (clr_flowid),
    .timeout_val    (timeout_val),
    .timeout_flowid (timeout_flowid),
    .timeout_rdy    (timeout_rdy)
  );

  // Write priority per flow: arm, then disarm, then the scanner's clear-on-expire.
  always_comb begin
    for (int i = 0; i < NUM_FLOWS; i++) begin
      tbl_d[i] = tbl_q[i];
      if (arm_val && (arm_flowid == FLOWID_W'(i))) begin
        tbl_d[i].timestamp   = now_q;
        tbl_d[i].timer_armed = 1'b1;
      end else if (disarm_val && (disarm_flowid == FLOWID_W'(i))) begin
        tbl_d[i].timer_armed = 1'b0;
      end else if (clr_val && (clr_flowid == FLOWID_W'(i))) begin
        tbl_d[i].timer_armed = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_q <= '0;
      for (int i = 0; i < NUM_FLOWS; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      now_q <= now_d;
      for (int i = 0; i < NUM_FLOWS; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  assign now = now_q;

endmodule

// File: tb/tb_tcp_rt_timer.sv
module tb_tcp_rt_timer;
  import tcp_pkg::*;

  localparam int NF = 8;
  localparam int TO = 20;

  logic                   clk;
  logic                   rst_n;
  logic                   arm_val;
  logic [FLOWID_W-1:0]    arm_flowid;
  logic                   disarm_val;
  logic [FLOWID_W-1:0]    disarm_flowid;
  logic                   timeout_val;
  logic [FLOWID_W-1:0]    timeout_flowid;
  logic                   timeout_rdy;
  logic [TIMESTAMP_W-1:0] now;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  logic prev_val = 1'b0;
  longint unsigned rises_now[$];
  int              rises_fid[$];

  tcp_rt_timer #(.NUM_FLOWS(NF), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .arm_val(arm_val), .arm_flowid(arm_flowid),
    .disarm_val(disarm_val), .disarm_flowid(disarm_flowid),
    .timeout_val(timeout_val), .timeout_flowid(timeout_flowid),
    .timeout_rdy(timeout_rdy), .now(now)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the table and the scanner position as plain integers.
  logic [63:0] m_now;
  logic [63:0] m_ts [NF];
  logic        m_armed [NF];
  int          m_ptr;
  logic        m_hold;
  int          m_flow;

  always @(posedge clk or negedge rst_n) begin : model
    logic [63:0] ts_n [NF];
    logic        ar_n [NF];
    int          ptr_n;
    logic        hold_n;
    int          flow_n;
    if (!rst_n) begin
      m_now  <= 64'd0;
      m_ptr  <= 0;
      m_hold <= 1'b0;
      m_flow <= 0;
      for (int i = 0; i < NF; i++) begin
        m_ts[i]    <= 64'd0;
        m_armed[i] <= 1'b0;
      end
    end else begin
      ts_n = m_ts; ar_n = m_armed; ptr_n = m_ptr; hold_n = m_hold; flow_n = m_flow;
      if (m_hold) begin
        if (timeout_rdy) hold_n = 1'b0;
      end else begin
        if (m_armed[m_ptr] && (m_now - m_ts[m_ptr]) >= 64'(TO) &&
            !(arm_val && int'(arm_flowid) == m_ptr)) begin
          hold_n = 1'b1;
          flow_n = m_ptr;
          ar_n[m_ptr] = 1'b0;
        end
        ptr_n = (m_ptr + 1) % NF;
      end
      if (disarm_val) ar_n[disarm_flowid] = 1'b0;
      if (arm_val) begin
        ar_n[arm_flowid] = 1'b1;
        ts_n[arm_flowid] = m_now;
      end
      m_ts <= ts_n; m_armed <= ar_n; m_ptr <= ptr_n; m_hold <= hold_n; m_flow <= flow_n;
      m_now <= m_now + 64'd1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus event recording.
  always @(negedge clk) begin
    chk("now", now, m_now);
    chk("timeout_val", 64'(timeout_val), 64'(m_hold));
    chk("timeout_flowid", 64'(timeout_flowid), 64'(m_flow));
    if (timeout_val && !prev_val) begin
      rises_now.push_back(now);
      rises_fid.push_back(int'(timeout_flowid));
    end
    if (timeout_val && timeout_rdy) hs_cnt++;
    prev_val = timeout_val;
  end

  function automatic logic [63:0] rn(input int k);
    return (k < rises_now.size()) ? 64'(rises_now[k]) : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction
  function automatic logic [63:0] rf(input int k);
    return (k < rises_fid.size()) ? 64'(rises_fid[k]) : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log;
    rises_now.delete();
    rises_fid.delete();
    hs_cnt = 0;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    arm_val    = 1'b0;
    disarm_val = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
  endtask

  task automatic arm(input int f);
    arm_val = 1'b1; arm_flowid = FLOWID_W'(f);
    tick(1);
    arm_val = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; arm_val = 1'b0; arm_flowid = '0;
    disarm_val = 1'b0; disarm_flowid = '0; timeout_rdy = 1'b1;
    #1;
    chk("reset_now", now, 64'd0);
    chk("reset_val", 64'(timeout_val), 64'd0);
    chk("reset_flowid", 64'(timeout_flowid), 64'd0);

    // Basic expiry: flow 3 armed at now=5, scanned at 27, notified at 28.
    do_reset();
    tick(5);
    arm(3);
    tick(60);
    chk("basic_count", 64'(rises_now.size()), 64'd1);
    chk("basic_now", rn(0), 64'd28);
    chk("basic_fid", rf(0), 64'd3);
    chk("basic_hs", 64'(hs_cnt), 64'd1);

    // Disarm after 10 cycles: nothing for 100 cycles.
    do_reset();
    arm(2);
    tick(9);
    disarm_val = 1'b1; disarm_flowid = 3'd2;
    tick(1);
    disarm_val = 1'b0;
    tick(100);
    chk("disarm_count", 64'(rises_now.size()), 64'd0);

    // Re-arm at now=15: expires from 35, scanned at 41, notified at 42.
    do_reset();
    arm(1);
    tick(14);
    arm(1);
    tick(60);
    chk("rearm_count", 64'(rises_now.size()), 64'd1);
    chk("rearm_now", rn(0), 64'd42);
    chk("rearm_fid", rf(0), 64'd1);

    // Backpressure: flow 0 held from 25 to 55, then flow 4 at 60.
    do_reset();
    timeout_rdy = 1'b0;
    arm(0);
    arm(4);
    tick(53);
    chk("bp_held", 64'(timeout_val), 64'd1);
    chk("bp_held_fid", 64'(timeout_flowid), 64'd0);
    timeout_rdy = 1'b1;
    tick(20);
    chk("bp_count", 64'(rises_now.size()), 64'd2);
    chk("bp_now0", rn(0), 64'd25);
    chk("bp_fid0", rf(0), 64'd0);
    chk("bp_now1", rn(1), 64'd60);
    chk("bp_fid1", rf(1), 64'd4);
    chk("bp_hs", 64'(hs_cnt), 64'd2);

    // Arm/expire collision on flow 6 at now=22: re-armed, notified at 47.
    do_reset();
    arm(6);
    tick(21);
    arm(6);
    tick(40);
    chk("coll_count", 64'(rises_now.size()), 64'd1);
    chk("coll_now", rn(0), 64'd47);
    chk("coll_fid", rf(0), 64'd6);

    // Reset while flow 5 is held; flow 7 is also armed and must be lost.
    do_reset();
    timeout_rdy = 1'b0;
    arm(5);
    arm(7);
    tick(28);
    chk("rst_pre_val", 64'(timeout_val), 64'd1);
    chk("rst_pre_fid", 64'(timeout_flowid), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_async_val", 64'(timeout_val), 64'd0);
    chk("rst_async_fid", 64'(timeout_flowid), 64'd0);
    chk("rst_async_now", now, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
    timeout_rdy = 1'b1;
    tick(100);
    chk("rst_post_count", 64'(rises_now.size()), 64'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
